// File: rtl/hazard_forward_ctrl_pkg.sv
// rtl/hazard_forward_ctrl_pkg.sv - shared types and constants for the hazard/forwarding controller
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } haz_state_e;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// rtl/hazard_forward_ctrl_if.sv - pipeline-facing signal bundle of the hazard/forwarding controller
interface hazard_forward_ctrl_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] id_ex_rs;
  logic [REG_AW-1:0] id_ex_rt;
  logic              id_ex_mem_read;
  logic [REG_AW-1:0] if_id_rs;
  logic [REG_AW-1:0] if_id_rt;
  logic              if_id_uses_rt;
  logic              ex_mem_reg_write;
  logic [REG_AW-1:0] ex_mem_rd;
  logic              ex_mem_mem_access;
  logic              mem_ready;
  logic              mem_wb_reg_write;
  logic [REG_AW-1:0] mem_wb_rd;
  logic              ex_branch_taken;
  logic [1:0]        forward_a;
  logic [1:0]        forward_b;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic              mem_freeze;
  logic [31:0]       stall_cycles;

  modport master (
    output id_ex_rs, id_ex_rt, id_ex_mem_read, if_id_rs, if_id_rt, if_id_uses_rt,
           ex_mem_reg_write, ex_mem_rd, ex_mem_mem_access, mem_ready,
           mem_wb_reg_write, mem_wb_rd, ex_branch_taken,
    input  forward_a, forward_b, pc_write, if_id_write, if_id_flush, id_ex_bubble,
           mem_freeze, stall_cycles
  );

  modport slave (
    input  id_ex_rs, id_ex_rt, id_ex_mem_read, if_id_rs, if_id_rt, if_id_uses_rt,
           ex_mem_reg_write, ex_mem_rd, ex_mem_mem_access, mem_ready,
           mem_wb_reg_write, mem_wb_rd, ex_branch_taken,
    output forward_a, forward_b, pc_write, if_id_write, if_id_flush, id_ex_bubble,
           mem_freeze, stall_cycles
  );

endinterface

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// rtl/hazard_forward_ctrl_fwd_select.sv - one-operand ALU forwarding select, EX/MEM over MEM/WB
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_ex_mem_reg_write,
  input  logic [REG_AW-1:0] i_ex_mem_rd,
  input  logic              i_mem_wb_reg_write,
  input  logic [REG_AW-1:0] i_mem_wb_rd,
  output logic [1:0]        o_sel
);

  logic w_ex_hit;
  logic w_wb_hit;

  assign w_ex_hit = i_ex_mem_reg_write && (i_ex_mem_rd != '0) && (i_ex_mem_rd == i_src);
  assign w_wb_hit = i_mem_wb_reg_write && (i_mem_wb_rd != '0) && (i_mem_wb_rd == i_src);

  assign o_sel = w_ex_hit ? FWD_EXMEM : (w_wb_hit ? FWD_MEMWB : FWD_REG);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - forwarding selects plus load-use/freeze/flush sequencing
// Optional stall-cycle performance counter built when HAZ_PERF_CNT_EN is defined.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW          = 5,
  parameter int LOAD_USE_STALLS = 1,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic rst_n,
  hazard_forward_ctrl_if.slave bus
);

  haz_state_e       r_state, w_state_nxt;
  haz_state_e       r_ret, w_ret_nxt;
  haz_state_e       w_eff;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic       w_lu_haz;
  logic       w_mw;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_pc_write;
  logic       w_if_id_write;
  logic       w_flush;
  logic       w_bubble;
  logic       w_freeze;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .i_src              (bus.id_ex_rs),
    .i_ex_mem_reg_write (bus.ex_mem_reg_write),
    .i_ex_mem_rd        (bus.ex_mem_rd),
    .i_mem_wb_reg_write (bus.mem_wb_reg_write),
    .i_mem_wb_rd        (bus.mem_wb_rd),
    .o_sel              (w_fwd_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .i_src              (bus.id_ex_rt),
    .i_ex_mem_reg_write (bus.ex_mem_reg_write),
    .i_ex_mem_rd        (bus.ex_mem_rd),
    .i_mem_wb_reg_write (bus.mem_wb_reg_write),
    .i_mem_wb_rd        (bus.mem_wb_rd),
    .o_sel              (w_fwd_b)
  );

  assign w_lu_haz = bus.id_ex_mem_read && (bus.id_ex_rt != '0) &&
                    ((bus.id_ex_rt == bus.if_id_rs) ||
                     (bus.if_id_uses_rt && (bus.id_ex_rt == bus.if_id_rt)));
  assign w_mw     = bus.ex_mem_mem_access && !bus.mem_ready;

  // MEM_WAIT behaves as its saved return state once memory is ready.
  always_comb begin
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_flush       = 1'b0;
    w_bubble      = 1'b0;
    w_freeze      = 1'b0;
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_ret_nxt     = r_ret;
    w_eff         = (r_state == MEM_WAIT) ? r_ret : r_state;
    if (!rst_n) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_ret_nxt   = IDLE;
    end else if (w_mw) begin
      w_freeze      = 1'b1;
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_state_nxt   = MEM_WAIT;
      w_ret_nxt     = w_eff;
    end else if (bus.ex_branch_taken) begin
      w_flush     = 1'b1;
      w_bubble    = 1'b1;
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_ret_nxt   = IDLE;
    end else if (w_eff == LU_STALL) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_bubble      = 1'b1;
      w_ret_nxt     = IDLE;
      if (r_cnt == CNT_W'(1)) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = LU_STALL;
        w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
    end else if (w_lu_haz) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_bubble      = 1'b1;
      w_ret_nxt     = IDLE;
      if (LOAD_USE_STALLS > 1) begin
        w_state_nxt = LU_STALL;
        w_cnt_nxt   = CNT_W'(LOAD_USE_STALLS - 1);
      end else begin
        w_state_nxt = IDLE;
      end
    end else begin
      w_state_nxt = IDLE;
      w_ret_nxt   = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ret   <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ret   <= w_ret_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.forward_a    = rst_n ? w_fwd_a : FWD_REG;
  assign bus.forward_b    = rst_n ? w_fwd_b : FWD_REG;
  assign bus.pc_write     = w_pc_write;
  assign bus.if_id_write  = w_if_id_write;
  assign bus.if_id_flush  = w_flush;
  assign bus.id_ex_bubble = w_bubble;
  assign bus.mem_freeze   = w_freeze;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (!w_pc_write && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
`else
  assign bus.stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - scoreboard bench with LOAD_USE_STALLS=1 and =3 instances
module tb_hazard_forward_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       mr;
    logic [4:0] frs;
    logic [4:0] frt;
    logic       urt;
    logic       exw;
    logic [4:0] exrd;
    logic       exma;
    logic       mrdy;
    logic       wbw;
    logic [4:0] wbrd;
    logic       br;
  } in_t;

  typedef struct {
    int          idx;
    int          sel;
    logic [8:0]  ctl;
    logic [31:0] sc;
  } exp_t;

  // ctl = {forward_a, forward_b, pc_write, if_id_write, if_id_flush, id_ex_bubble, mem_freeze}
  localparam logic [8:0] C_RUN   = 9'b00_00_11000;
  localparam logic [8:0] C_STALL = 9'b00_00_00010;
  localparam logic [8:0] C_FRZ   = 9'b00_00_00001;
  localparam logic [8:0] C_FLUSH = 9'b00_00_11110;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  in1, in3, idle_in;
  exp_t scb[$];
  exp_t mon_x;
  logic [8:0]  mon_ctl;
  logic [31:0] mon_sc;
  int   checks = 0;
  int   errors = 0;
  int   vec_n = 0;
  int   sc_model[2];

  always #5 clk = ~clk;

  hazard_forward_ctrl_if #(.REG_AW(5)) bus1 ();
  hazard_forward_ctrl_if #(.REG_AW(5)) bus3 ();

  hazard_forward_ctrl #(.REG_AW(5), .LOAD_USE_STALLS(1), .CNT_W(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  hazard_forward_ctrl #(.REG_AW(5), .LOAD_USE_STALLS(3), .CNT_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  assign bus1.id_ex_rs          = in1.rs;
  assign bus1.id_ex_rt          = in1.rt;
  assign bus1.id_ex_mem_read    = in1.mr;
  assign bus1.if_id_rs          = in1.frs;
  assign bus1.if_id_rt          = in1.frt;
  assign bus1.if_id_uses_rt     = in1.urt;
  assign bus1.ex_mem_reg_write  = in1.exw;
  assign bus1.ex_mem_rd         = in1.exrd;
  assign bus1.ex_mem_mem_access = in1.exma;
  assign bus1.mem_ready         = in1.mrdy;
  assign bus1.mem_wb_reg_write  = in1.wbw;
  assign bus1.mem_wb_rd         = in1.wbrd;
  assign bus1.ex_branch_taken   = in1.br;

  assign bus3.id_ex_rs          = in3.rs;
  assign bus3.id_ex_rt          = in3.rt;
  assign bus3.id_ex_mem_read    = in3.mr;
  assign bus3.if_id_rs          = in3.frs;
  assign bus3.if_id_rt          = in3.frt;
  assign bus3.if_id_uses_rt     = in3.urt;
  assign bus3.ex_mem_reg_write  = in3.exw;
  assign bus3.ex_mem_rd         = in3.exrd;
  assign bus3.ex_mem_mem_access = in3.exma;
  assign bus3.mem_ready         = in3.mrdy;
  assign bus3.mem_wb_reg_write  = in3.wbw;
  assign bus3.mem_wb_rd         = in3.wbrd;
  assign bus3.ex_branch_taken   = in3.br;

  function automatic in_t mk(logic [4:0] rs, logic [4:0] rt, logic mr,
                             logic [4:0] frs, logic [4:0] frt, logic urt,
                             logic exw, logic [4:0] exrd, logic exma, logic mrdy,
                             logic wbw, logic [4:0] wbrd, logic br);
    in_t d;
    d = '{rs: rs, rt: rt, mr: mr, frs: frs, frt: frt, urt: urt, exw: exw, exrd: exrd,
          exma: exma, mrdy: mrdy, wbw: wbw, wbrd: wbrd, br: br};
    return d;
  endfunction

  task automatic v(input int sel, input logic r, input in_t d, input logic [8:0] e);
    exp_t x;
    int   k;
    @(posedge clk);
    #1;
    k = (sel == 3) ? 1 : 0;
    rst_n = r;
    in1 = (sel == 1) ? d : idle_in;
    in3 = (sel == 3) ? d : idle_in;
    x.idx = vec_n;
    x.sel = sel;
    x.ctl = e;
`ifdef HAZ_PERF_CNT_EN
    x.sc = 32'(sc_model[k]);
`else
    x.sc = 32'd0;
`endif
    scb.push_back(x);
    vec_n++;
    if (!r) begin
      sc_model[0] = 0;
      sc_model[1] = 0;
    end else if (!e[4]) begin
      sc_model[k] = sc_model[k] + 1;
    end
  endtask

  always @(negedge clk) begin
    if (scb.size() > 0) begin
      mon_x = scb.pop_front();
      if (mon_x.sel == 1) begin
        mon_ctl = {bus1.forward_a, bus1.forward_b, bus1.pc_write, bus1.if_id_write,
                   bus1.if_id_flush, bus1.id_ex_bubble, bus1.mem_freeze};
        mon_sc  = bus1.stall_cycles;
      end else begin
        mon_ctl = {bus3.forward_a, bus3.forward_b, bus3.pc_write, bus3.if_id_write,
                   bus3.if_id_flush, bus3.id_ex_bubble, bus3.mem_freeze};
        mon_sc  = bus3.stall_cycles;
      end
      checks++;
      if (mon_ctl !== mon_x.ctl) begin
        errors++;
        $display("FAIL vec%0d ctl (dut L=%0d): got %b expected %b",
                 mon_x.idx, mon_x.sel, mon_ctl, mon_x.ctl);
      end
      checks++;
      if (mon_sc !== mon_x.sc) begin
        errors++;
        $display("FAIL vec%0d stall_cycles (dut L=%0d): got %0d expected %0d",
                 mon_x.idx, mon_x.sel, mon_sc, mon_x.sc);
      end
    end
  end

  initial begin
    idle_in = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    in1 = idle_in;
    in3 = idle_in;
    sc_model[0] = 0;
    sc_model[1] = 0;
    repeat (2) @(posedge clk);

    // reset defaults even with every hazard/forward input active
    v(1, 0, mk(3, 3, 1, 3, 3, 1, 1, 3, 1, 0, 1, 3, 1), C_RUN);
    v(3, 0, mk(3, 3, 1, 3, 3, 1, 1, 3, 1, 0, 1, 3, 1), C_RUN);

    // forwarding priority
    v(1, 1, mk(3, 5, 0, 0, 0, 0, 1, 3, 0, 1, 1, 3, 0), {2'b10, 2'b00, 5'b11000});
    v(1, 1, mk(3, 5, 0, 0, 0, 0, 0, 3, 0, 1, 1, 3, 0), {2'b01, 2'b00, 5'b11000});
    v(1, 1, mk(3, 5, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0), {2'b00, 2'b00, 5'b11000});
    v(1, 1, mk(3, 7, 0, 0, 0, 0, 1, 7, 0, 1, 1, 3, 0), {2'b01, 2'b10, 5'b11000});

    // load-use with one bubble
    v(1, 1, mk(0, 8, 1, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0), C_STALL);
    v(1, 1, mk(0, 0, 0, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0), C_RUN);
    v(1, 1, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), C_RUN);
    v(1, 1, mk(0, 9, 1, 1, 9, 0, 0, 0, 0, 1, 0, 0, 0), C_RUN);
    v(1, 1, mk(0, 9, 1, 1, 9, 1, 0, 0, 0, 1, 0, 0, 0), C_STALL);
    v(1, 1, idle_in, C_RUN);

    // three-bubble load-use
    v(3, 1, mk(0, 8, 1, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0), C_STALL);
    v(3, 1, idle_in, C_STALL);
    v(3, 1, idle_in, C_STALL);
    v(3, 1, idle_in, C_RUN);

    // memory freeze after the first bubble
    v(3, 1, mk(0, 8, 1, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0), C_STALL);
    for (int i = 0; i < 4; i++) v(3, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), C_FRZ);
    v(3, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), C_STALL);
    v(3, 1, idle_in, C_STALL);
    v(3, 1, idle_in, C_RUN);

    // branch inside LU_STALL
    v(3, 1, mk(0, 8, 1, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0), C_STALL);
    v(3, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1), C_FLUSH);
    v(3, 1, idle_in, C_RUN);

    // branch together with a memory wait
    v(3, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), C_FRZ);
    v(3, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1), C_FLUSH);
    v(3, 1, idle_in, C_RUN);

    // reset while in MEM_WAIT entered from LU_STALL
    v(3, 1, mk(0, 8, 1, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0), C_STALL);
    v(3, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), C_FRZ);
    v(3, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), C_RUN);
    v(3, 1, idle_in, C_RUN);
    v(3, 1, mk(0, 4, 1, 0, 4, 1, 0, 0, 0, 1, 0, 0, 0), C_STALL);
    v(3, 1, idle_in, C_STALL);
    v(3, 1, idle_in, C_STALL);
    v(3, 1, idle_in, C_RUN);
    v(1, 1, idle_in, C_RUN);

    for (int i = 0; i < 10 && scb.size() > 0; i++) @(posedge clk);
    if (scb.size() > 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", scb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
